// File: rtl/fetch_line_queue.sv
// =============================================================================
// fetch_line_queue : 4 x 16-byte circular instruction byte queue with window.
// Optional feature macro: FE_SEG_LIMIT_CHECK_EN.  Revision: 1.0
// =============================================================================
`default_nettype none

module fetch_line_queue (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_eip,
  input  logic [31:0]  eip_in,
  output logic         icache_en,
  output logic [31:0]  icache_address,
  input  logic         icache_ready,
  input  logic [127:0] icache_data,
  input  logic [31:0]  cs_limit,
  input  logic         consume,
  input  logic [3:0]   consume_len,
  output logic         win_valid,
  output logic [127:0] window,
  output logic [31:0]  eip_out,
  output logic [5:0]   rd_ptr,
  output logic         segment_limit_exception
);

  localparam logic [2:0] C_DEPTH = 3'd4;

  logic [127:0] mem_q [4];
  logic [1:0]   wr_idx_q, wr_idx_d;
  logic [2:0]   count_q, count_d;
  logic [5:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]  fetch_addr_q, fetch_addr_d;
  logic [31:0]  eip_q, eip_d;

  logic         w_limit_block;
  logic         w_fill;
  logic         w_consume;
  logic         w_free;
  logic [5:0]   w_rd_next;
  logic [255:0] w_pair;
  logic [255:0] w_shift;
  logic [127:0] w_unused_hi;

`ifdef FE_SEG_LIMIT_CHECK_EN
  logic exc_q, exc_d;

  assign w_limit_block = (fetch_addr_q > cs_limit);

  always_comb begin
    exc_d = exc_q;
    if (load_eip) begin
      exc_d = 1'b0;
    end else if (!win_valid && w_limit_block && (count_q < C_DEPTH)) begin
      exc_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exc_q <= 1'b0;
    end else begin
      exc_q <= exc_d;
    end
  end

  assign segment_limit_exception = exc_q;
`else
  logic w_unused_limit;

  assign w_limit_block           = 1'b0;
  assign w_unused_limit          = ^cs_limit;
  assign segment_limit_exception = 1'b0;
`endif

  assign icache_en      = (count_q < C_DEPTH) && !reset && !w_limit_block;
  assign icache_address = fetch_addr_q;
  assign win_valid      = !reset &&
                          ((count_q >= 3'd2) || ((count_q >= 3'd1) && (rd_ptr_q[3:0] == 4'd0)));

  // Current entry in the low half so a right shift by the byte offset aligns byte 0.
  assign w_pair      = {mem_q[rd_ptr_q[5:4] + 2'd1], mem_q[rd_ptr_q[5:4]]};
  assign w_shift     = w_pair >> {rd_ptr_q[3:0], 3'b000};
  assign window      = w_shift[127:0];
  assign w_unused_hi = w_shift[255:128];

  assign eip_out = eip_q;
  assign rd_ptr  = rd_ptr_q;

  assign w_fill    = icache_en && icache_ready && !load_eip;
  assign w_consume = consume && win_valid && (consume_len != 4'd0) && !load_eip;
  assign w_rd_next = rd_ptr_q + {2'b00, consume_len};
  assign w_free    = w_consume && (w_rd_next[5:4] != rd_ptr_q[5:4]);

  always_comb begin
    wr_idx_d     = wr_idx_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    fetch_addr_d = fetch_addr_q;
    eip_d        = eip_q;
    if (load_eip) begin
      wr_idx_d     = 2'd0;
      count_d      = 3'd0;
      rd_ptr_d     = {2'b00, eip_in[3:0]};
      fetch_addr_d = {eip_in[31:4], 4'h0};
      eip_d        = eip_in;
    end else begin
      if (w_fill) begin
        wr_idx_d     = wr_idx_q + 2'd1;
        fetch_addr_d = fetch_addr_q + 32'd16;
      end
      if (w_consume) begin
        rd_ptr_d = w_rd_next;
        eip_d    = eip_q + {28'd0, consume_len};
      end
      count_d = count_q + {2'b00, w_fill} - {2'b00, w_free};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx_q     <= 2'd0;
      count_q      <= 3'd0;
      rd_ptr_q     <= 6'd0;
      fetch_addr_q <= 32'd0;
      eip_q        <= 32'd0;
    end else begin
      wr_idx_q     <= wr_idx_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      fetch_addr_q <= fetch_addr_d;
      eip_q        <= eip_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= '0;
      end
    end else if (w_fill) begin
      mem_q[wr_idx_q] <= icache_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_line_queue.sv
// =============================================================================
// tb_fetch_line_queue : vector table plus request-address scoreboard bench.
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_fetch_line_queue;

  logic         clk;
  logic         reset;
  logic         load_eip;
  logic [31:0]  eip_in;
  logic         icache_en;
  logic [31:0]  icache_address;
  logic         icache_ready;
  logic [127:0] icache_data;
  logic [31:0]  cs_limit;
  logic         consume;
  logic [3:0]   consume_len;
  logic         win_valid;
  logic [127:0] window;
  logic [31:0]  eip_out;
  logic [5:0]   rd_ptr;
  logic         segment_limit_exception;

  int n_tests;
  int n_fail;
  logic [31:0] exp_q [$];

  fetch_line_queue dut (
    .clk                     (clk),
    .reset                   (reset),
    .load_eip                (load_eip),
    .eip_in                  (eip_in),
    .icache_en               (icache_en),
    .icache_address          (icache_address),
    .icache_ready            (icache_ready),
    .icache_data             (icache_data),
    .cs_limit                (cs_limit),
    .consume                 (consume),
    .consume_len             (consume_len),
    .win_valid               (win_valid),
    .window                  (window),
    .eip_out                 (eip_out),
    .rd_ptr                  (rd_ptr),
    .segment_limit_exception (segment_limit_exception)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [127:0] bytes_from(input logic [31:0] a);
    logic [127:0] w;
    w = '0;
    for (int k = 0; k < 16; k++) begin
      w[8*k +: 8] = byte_at(a + k);
    end
    return w;
  endfunction

  always_comb icache_data = bytes_from(icache_address);

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every accepted fill must match the next expected request address.
  always @(negedge clk) begin
    if (!reset && !load_eip && icache_en && icache_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_fill", {96'd0, icache_address}, {128{1'b1}});
      end else begin
        check("fill_addr", {96'd0, icache_address}, {96'd0, exp_q.pop_front()});
      end
    end
  end

  typedef struct {
    logic        cons;
    logic [3:0]  len;
    logic        rdy;
    logic        fill;
    logic [31:0] faddr;
    logic [5:0]  rd;
    logic [31:0] eip;
    logic        en;
    logic        vld;
  } vec_t;

  vec_t vecs [17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1; load_eip = 1'b0; eip_in = '0; icache_ready = 1'b1;
    cs_limit = 32'hFFFF_FFFF; consume = 1'b0; consume_len = '0;

    //                cons len rdy fill faddr  rd  eip    en vld
    vecs[0]  = '{1'b1, 4'd15, 1'b0, 1'b0, 32'h00, 6'd15, 32'h0F, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 4'd1,  1'b0, 1'b0, 32'h00, 6'd16, 32'h10, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 4'd5,  1'b0, 1'b0, 32'h00, 6'd16, 32'h10, 1'b1, 1'b1};
    vecs[3]  = '{1'b1, 4'd0,  1'b0, 1'b0, 32'h00, 6'd16, 32'h10, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 4'd0,  1'b1, 1'b1, 32'h40, 6'd16, 32'h10, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 4'd15, 1'b0, 1'b0, 32'h00, 6'd31, 32'h1F, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 4'd15, 1'b0, 1'b0, 32'h00, 6'd46, 32'h2E, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 4'd15, 1'b0, 1'b0, 32'h00, 6'd61, 32'h3D, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 4'd3,  1'b0, 1'b0, 32'h00, 6'd0,  32'h40, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 4'd1,  1'b0, 1'b0, 32'h00, 6'd1,  32'h41, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 4'd1,  1'b0, 1'b0, 32'h00, 6'd1,  32'h41, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 4'd0,  1'b1, 1'b1, 32'h50, 6'd1,  32'h41, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 4'd15, 1'b1, 1'b1, 32'h60, 6'd16, 32'h50, 1'b1, 1'b1};
    vecs[13] = '{1'b1, 4'd15, 1'b1, 1'b1, 32'h70, 6'd31, 32'h5F, 1'b1, 1'b1};
    vecs[14] = '{1'b1, 4'd15, 1'b1, 1'b1, 32'h80, 6'd46, 32'h6E, 1'b1, 1'b1};
    vecs[15] = '{1'b1, 4'd15, 1'b0, 1'b0, 32'h00, 6'd61, 32'h7D, 1'b1, 1'b1};
    vecs[16] = '{1'b1, 4'd3,  1'b1, 1'b1, 32'h90, 6'd0,  32'h80, 1'b1, 1'b1};

    tick();
    tick();
    check("rst_en",  {127'd0, icache_en}, 128'd0);
    check("rst_vld", {127'd0, win_valid}, 128'd0);
    check("rst_rd",  {122'd0, rd_ptr},    128'd0);
    check("rst_eip", {96'd0, eip_out},    128'd0);

    // Zero-wait fill of the empty queue from address 0.
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(16 * i));
    reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("fill_en",   {127'd0, icache_en},     128'd1);
      check("fill_addr", {96'd0, icache_address}, {96'd0, 32'(16 * i)});
      tick();
      if (i == 0) begin
        check("first_vld", {127'd0, win_valid}, 128'd1);
        check("first_win", window, bytes_from(32'h0));
      end
    end
    check("full_en", {127'd0, icache_en}, 128'd0);

    for (int v = 0; v < 17; v++) begin
      consume      = vecs[v].cons;
      consume_len  = vecs[v].len;
      icache_ready = vecs[v].rdy;
      if (vecs[v].fill) exp_q.push_back(vecs[v].faddr);
      tick();
      check($sformatf("v%0d_rd", v),  {122'd0, rd_ptr},    {122'd0, vecs[v].rd});
      check($sformatf("v%0d_eip", v), {96'd0, eip_out},    {96'd0, vecs[v].eip});
      check($sformatf("v%0d_en", v),  {127'd0, icache_en}, {127'd0, vecs[v].en});
      check($sformatf("v%0d_vld", v), {127'd0, win_valid}, {127'd0, vecs[v].vld});
      if (vecs[v].vld) check($sformatf("v%0d_win", v), window, bytes_from(vecs[v].eip));
    end
    consume = 1'b0; consume_len = '0;

    // Redirect to an unaligned target while a line is being returned.
    load_eip = 1'b1; eip_in = 32'h1237; icache_ready = 1'b1;
    tick();
    load_eip = 1'b0;
    exp_q.push_back(32'h1230);
    exp_q.push_back(32'h1240);
    check("redir_en",   {127'd0, icache_en},     128'd1);
    check("redir_addr", {96'd0, icache_address}, {96'd0, 32'h1230});
    check("redir_rd",   {122'd0, rd_ptr},        128'd7);
    check("redir_eip",  {96'd0, eip_out},        {96'd0, 32'h1237});
    check("redir_vld0", {127'd0, win_valid},     128'd0);
    tick();
    check("redir_vld1", {127'd0, win_valid},     128'd0);
    tick();
    icache_ready = 1'b0;
    check("redir_vld2", {127'd0, win_valid},     128'd1);
    check("redir_win",  window, bytes_from(32'h1237));
    check("exc_idle",   {127'd0, segment_limit_exception}, 128'd0);

`ifdef FE_SEG_LIMIT_CHECK_EN
    cs_limit = 32'h2F;
    load_eip = 1'b1; eip_in = 32'h0;
    tick();
    load_eip = 1'b0; icache_ready = 1'b1;
    exp_q.push_back(32'h00);
    exp_q.push_back(32'h10);
    exp_q.push_back(32'h20);
    for (int i = 0; i < 4; i++) tick();
    icache_ready = 1'b0;
    check("lim_en",   {127'd0, icache_en}, 128'd0);
    check("lim_exc0", {127'd0, segment_limit_exception}, 128'd0);
    consume = 1'b1; consume_len = 4'd15;
    for (int i = 0; i < 3; i++) tick();
    consume = 1'b0; consume_len = '0;
    tick();
    tick();
    check("lim_exc1", {127'd0, segment_limit_exception}, 128'd1);
    load_eip = 1'b1; eip_in = 32'h100;
    tick();
    load_eip = 1'b0; cs_limit = 32'hFFFF_FFFF;
    check("lim_clr", {127'd0, segment_limit_exception}, 128'd0);
    tick();
`endif

    // Reset in the middle of operation with a line returning.
    reset = 1'b1; icache_ready = 1'b1;
    tick();
    check("mid_rst_en",  {127'd0, icache_en}, 128'd0);
    check("mid_rst_vld", {127'd0, win_valid}, 128'd0);
    check("mid_rst_rd",  {122'd0, rd_ptr},    128'd0);
    check("mid_rst_eip", {96'd0, eip_out},    128'd0);
    reset = 1'b0; icache_ready = 1'b0;
    #1;
    check("post_rst_en",   {127'd0, icache_en},     128'd1);
    check("post_rst_addr", {96'd0, icache_address}, 128'd0);
    check("post_rst_exc",  {127'd0, segment_limit_exception}, 128'd0);
    tick();
    check("sb_empty", {96'd0, 32'(exp_q.size())}, 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_line_queue.md
# fetch_line_queue

Four-entry, 16-byte-per-entry circular instruction byte queue that sits directly upstream of the fetch window shifter and stage-1 decoder. It issues aligned line requests to the icache, stores returned 128-bit lines, and presents a 16-byte instruction window starting at the current byte read pointer. The decoder consumes it by instruction length. On a control-flow redirect (`load_eip`) the queue flushes and refills from the new EIP.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `load_eip`  in  1  redirect strobe; flush and refetch from `eip_in`
- `eip_in`  in  32  redirect target linear address
- `icache_en`  out  1  line request valid (level)
- `icache_address`  out  32  request address, always 16-byte aligned (`[3:0]=0`)
- `icache_ready`  in  1  `icache_data` valid for current `icache_address` this cycle
- `icache_data`  in  128  line; memory byte n at bits `[8n+7:8n]`
- `cs_limit`  in  32  code segment limit (byte offset, inclusive)
- `consume`  in  1  decoder retires `consume_len` bytes this cycle
- `consume_len`  in  4  bytes consumed; 0 = no-op
- `win_valid`  out  1  all 16 window bytes are valid
- `window`  out  128  window byte k (address `eip_out+k`) at `[8k+7:8k]`
- `eip_out`  out  32  linear address of window byte 0
- `rd_ptr`  out  6  byte index of window byte 0 in the 64-byte queue
- `segment_limit_exception`  out  1  sticky fetch-beyond-limit fault

## Operation
- State: four 128-bit entries; `wr_idx[1:0]`; `count[2:0]` (0..4 valid lines); `rd_ptr[5:0]`; `fetch_addr[31:0]`; `eip_out`.
- Request: `icache_en = (count<4) && !reset && !limit_block`. `icache_address = fetch_addr`, held stable until `icache_ready`.
- Fill (`icache_en && icache_ready`): entry[`wr_idx`] <= `icache_data`; `wr_idx`++ (mod 4); `fetch_addr` += 16; `count`++.
- Window: 32 bytes starting at entry `rd_ptr[5:4]` followed by the next entry (mod 4), shifted right by `rd_ptr[3:0]` bytes. The result is combinational.
- `win_valid = (count>=2) || (count>=1 && rd_ptr[3:0]==0)`.
- Consume (`consume && win_valid && consume_len!=0`):
  - `rd_ptr` += `consume_len` (mod 64); `eip_out` += `consume_len` (mod 2^32).
  - If `rd_ptr[5:4]` changes, free one entry (`count`--). A change occurs at most once, since `consume_len` ≤ 15.
- `consume` while `!win_valid` is ignored.
- Simultaneous fill and free: `count` is net unchanged; both pointer updates apply.
- Redirect (`load_eip`) has priority over fill and consume in the same cycle:
  - `count`<=0, `wr_idx`<=0, `rd_ptr`<={2'b00,`eip_in[3:0]`}.
  - `fetch_addr`<={`eip_in[31:4]`,4'h0}, `eip_out`<=`eip_in`.
  - A coincident `icache_ready` line is discarded; the request restarts at the new address next cycle.
  - `segment_limit_exception` clears.

## Timing
- Reset values: `count`=0, `wr_idx`=0, `rd_ptr`=0, `fetch_addr`=0, `eip_out`=0, `segment_limit_exception`=0, entries=0.
- While `reset` is high, `icache_en`=0 and `win_valid`=0.
- First request: `icache_en`=1 at address 0 in the first cycle after `reset` drops.
- Fill latency: line returned in cycle N is counted in `count` at N+1. With aligned `rd_ptr`, `win_valid`=1 at N+1.
- Cache with `icache_ready` tied high: one line per cycle; queue full after 4 cycles, then `icache_en`=0 until a line is freed.
- Free-to-request: a consume that frees an entry at edge N raises `icache_en` in cycle N (post-edge) if it was 0.
- Redirect to unaligned EIP: `win_valid` requires two lines, so earliest is 2 cycles after the redirect edge with a zero-wait cache.
- Reset mid-operation: all state returns to reset values at the edge; in-flight data ignored.

## Configuration
- Macro `FE_SEG_LIMIT_CHECK_EN`, when defined:
  - `limit_block = (fetch_addr > cs_limit)`; requests stop at the first line whose base exceeds the limit.
  - `segment_limit_exception` sets when `!win_valid && limit_block && count<4`, and holds until `load_eip` or `reset`.
- When undefined: `limit_block`=0, `cs_limit` is ignored, `segment_limit_exception` is tied 0.

## Test plan
- Reset release, `icache_ready`=1, data = line index → addresses 0x00, 0x10, 0x20, 0x30 on 4 consecutive cycles, then `icache_en`=0; `win_valid`=1 one cycle after the first fill; `window`=line 0.
- Full queue, consume 15, then 1 → `rd_ptr`=15 then 16; `count` 4→3 on the second consume; `icache_en`=1 at 0x40; `eip_out`=0x10.
- `load_eip` with `eip_in`=0x1237 while `icache_ready`=1 → returned line dropped; next request 0x1230; `rd_ptr`=7; `win_valid` after lines 0x1230 and 0x1240; `window` byte 0 = memory[0x1237].
- Fill and crossing consume in the same cycle, `count`=2 → `count` stays 2; `wr_idx` and `rd_ptr[5:4]` both advance; wraps correctly past entry 3.
- `consume` with `win_valid`=0, and `consume_len`=0 → no change to `rd_ptr`, `eip_out`, `count`.
- Macro on: `cs_limit`=0x2F, start EIP 0 → fills 0x00–0x20 only; after consuming through 0x2F, `segment_limit_exception`=1; `load_eip` clears it.
